mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Memory-access stage sitting directly downstream of Data_path. It consumes ALU_out as the effective address and Data_out as the store data, and runs a request/acknowledge transaction on the data-memory bus. It returns aligned, extended load data on Data_in and stalls the datapath until the transaction completes. Byte, halfword and word accesses use little-endian lane selection.

Parameters:
AW, 32, address width (ALU_out width)
DW, 32, data width
TIMEOUT, 16, bus-ack watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ALU_out  input  AW  effective address from datapath
Data_out  input  DW  store data from datapath (rt)
mem_read  input  1  load request, held while stall=1
mem_write  input  1  store request, held while stall=1
mem_size  input  2  00 byte, 01 half, 10 word, 11 illegal
load_unsigned  input  1  1: zero-extend loads, 0: sign-extend
Data_in  output  DW  load result to datapath DatatoReg mux (registered)
stall  output  1  freeze PC and pipeline registers
mem_err  output  1  one-cycle pulse on misaligned, illegal or timed-out access
bus_req  output  1  bus request (registered)
bus_we  output  1  1 = write
bus_addr  output  AW  word-aligned address, {ALU_out[AW-1:2],2'b00}
bus_be  output  4  byte-lane enables
bus_wdata  output  DW  lane-replicated store data
bus_ack  input  1  transaction complete; bus_rdata valid same cycle
bus_rdata  input  DW  read word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Data_in=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, mem_err=0. stall is combinational and therefore 0.
- access = mem_read|mem_write.
- illegal: mem_size=11, mem_read&mem_write, half with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, REQ, DONE.
- IDLE with access&!illegal:
  - stall=1 that cycle.
  - Register bus_req=1, bus_we=mem_write, bus_addr, bus_be and bus_wdata.
  - Next state REQ.
- IDLE with access&illegal:
  - No bus activity, stall=0.
  - mem_err=1 next cycle for exactly one cycle.
  - Data_in unchanged. Stay IDLE.
- REQ:
  - stall=1. bus_* held stable until bus_ack.
  - On bus_ack: bus_req=0 next cycle. If read, Data_in <= aligned/extended bus_rdata. Next state DONE.
- DONE:
  - stall=0 so the datapath advances. Still-present request inputs are ignored.
  - Next state IDLE. Back-to-back accesses therefore cost at least 3 cycles each.
- Minimum latency: request at cycle N, ack at N+1, Data_in valid and stall=0 at N+2.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
- Store data: byte replicated 4x, half replicated 2x, word unchanged.
- Load data: select the addressed lane, then extend to DW per load_unsigned. Word loads are not extended.
- Writes leave Data_in unchanged.
- bus_ack in IDLE or DONE is ignored.
- rst asserted mid-REQ: bus_req drops asynchronously and the transaction is abandoned; the bus must tolerate this.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. Reaching TIMEOUT-1:
  - Abort: bus_req=0, mem_err pulse, Data_in unchanged.
  - Go to DONE, which releases the stall.
- Undefined: no counter; REQ waits indefinitely for bus_ack.

Decomposition:
- Shared package mem_stage_pkg holds:
  - the state encoding (IDLE/REQ/DONE)
  - mem_size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the default TIMEOUT constant
- One natural sub-module: mem_lane_align, purely combinational. It produces bus_be and bus_wdata from address, size and store data, and the extended load word from rdata, address, size and load_unsigned.

Test Plan:
1. Reset then word load, addr 0x0000_0010, bus_rdata 0xDEAD_BEEF, ack at N+1 -> bus_addr 0x10, bus_be 1111, stall high N..N+1, Data_in 0xDEADBEEF at N+2.
2. Byte loads, addr 0x13, rdata 0x80FF_0000 -> Data_in 0xFFFFFF80 (signed), 0x00000080 (unsigned); bus_be 1000 in both cases.
3. Half store, addr 0x22, Data_out 0x1234_ABCD -> bus_we=1, bus_be 1100, bus_wdata 0xABCD_ABCD; Data_in unchanged.
4. Word load, addr 0x06 -> no bus_req, stall 0, mem_err pulse one cycle; mem_size=11 gives the same response.
5. Ack delayed 5 cycles -> stall high 6 cycles and bus_* stable throughout; with MEM_TIMEOUT_EN and TIMEOUT=4 -> abort, mem_err pulse, stall released.
6. rst low during REQ -> bus_req 0 immediately, state IDLE, Data_in 0; first access after reset completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: FSM states, mem_size codes, default watchdog.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data on the way out,
// lane select plus sign/zero extension of the read word on the way back.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    addr_lo,
    input  logic [1:0]    size,
    input  logic [DW-1:0] wdata,
    output logic [3:0]    be,
    output logic [DW-1:0] lane_wdata,
    input  logic [1:0]    rd_addr_lo,
    input  logic [1:0]    rd_size,
    input  logic          load_unsigned,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] load_data
);

    logic [DW-1:0] shifted;
    logic          sign_b;
    logic          sign_h;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rdata >> {rd_addr_lo, 3'b000};
    assign sign_b  = ~load_unsigned & shifted[7];
    assign sign_h  = ~load_unsigned & shifted[15];

    always_comb begin
        load_data = rdata;
        case (rd_size)
            SZ_BYTE: load_data = {{(DW-8){sign_b}}, shifted[7:0]};
            SZ_HALF: load_data = {{(DW-16){sign_h}}, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: req/ack data-bus transaction with datapath stall and error pulse.
// Optional bus-ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ALU_out,
    input  logic [DW-1:0] Data_out,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_size,
    input  logic          load_unsigned,
    output logic [DW-1:0] Data_in,
    output logic          stall,
    output logic          mem_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

    state_t        state;
    logic          access;
    logic          illegal;
    logic          start;
    logic [3:0]    be;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] load_data;
    logic [1:0]    rd_addr_lo;
    logic [1:0]    rd_size;
    logic          rd_unsigned;

    assign access  = mem_read | mem_write;
    assign illegal = (mem_size == SZ_ILL) | (mem_read & mem_write)
                   | ((mem_size == SZ_HALF) & ALU_out[0])
                   | ((mem_size == SZ_WORD) & (ALU_out[1:0] != 2'b00));
    assign start   = (state == StIdle) & access & ~illegal;
    assign stall   = rst & (start | (state == StReq));

    mem_lane_align #(
        .DW(DW)
    ) u_align (
        .addr_lo      (ALU_out[1:0]),
        .size         (mem_size),
        .wdata        (Data_out),
        .be           (be),
        .lane_wdata   (lane_wdata),
        .rd_addr_lo   (rd_addr_lo),
        .rd_size      (rd_size),
        .load_unsigned(rd_unsigned),
        .rdata        (bus_rdata),
        .load_data    (load_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            Data_in     <= '0;
            mem_err     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= 4'b0000;
            bus_wdata   <= '0;
            rd_addr_lo  <= 2'b00;
            rd_size     <= SZ_BYTE;
            rd_unsigned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            mem_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (access && illegal) begin
                        mem_err <= 1'b1;
                    end else if (access) begin
                        bus_req     <= 1'b1;
                        bus_we      <= mem_write;
                        bus_addr    <= {ALU_out[AW-1:2], 2'b00};
                        bus_be      <= be;
                        bus_wdata   <= lane_wdata;
                        rd_addr_lo  <= ALU_out[1:0];
                        rd_size     <= mem_size;
                        rd_unsigned <= load_unsigned;
                        state       <= StReq;
`ifdef MEM_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            Data_in <= load_data;
                        end
                        state <= StDone;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_out;
    logic [31:0] Data_out;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] Data_in;
    logic        stall;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .AW(32),
        .DW(32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_out      (ALU_out),
        .Data_out     (Data_out),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .load_unsigned(load_unsigned),
        .Data_in      (Data_in),
        .stall        (stall),
        .mem_err      (mem_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Expected per-cycle outputs, maintained by the driver from the transaction rules.
    logic        checking = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_err = 1'b0;
    logic        err_next = 1'b0;
    logic [31:0] exp_din = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wd = '0;

    logic [3:0]  last_be = '0;
    logic [31:0] last_wd = '0;
    logic        last_we = 1'b0;
    int          stall_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("bus_req", {31'b0, bus_req}, {31'b0, exp_req});
            chk("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
            chk("Data_in", Data_in, exp_din);
            if (exp_req) begin
                chk("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
                chk("bus_wdata", bus_wdata, exp_wd);
            end
        end
        if (bus_req) begin
            last_be <= bus_be;
            last_wd <= bus_wdata;
            last_we <= bus_we;
        end
        if (stall) stall_total <= stall_total + 1;
    end

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
        int          nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb = size_bytes(sz);
        if (nb == 4) return w;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (w >> (8 * off)) & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] r;
        int          nb;
        nb = size_bytes(sz);
        r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % nb) +: 8];
        return r;
    endfunction

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        exp_err  = err_next;
        err_next = 1'b0;
    endtask

    task automatic idle();
        begin_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
    endtask

    // One access: dly = REQ cycles before ack; rst_at = REQ cycle in which reset is asserted.
    task automatic access(input logic rd, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input logic [31:0] rdat,
                          input int dly, input logic both, input int rst_at);
        logic ill;
        logic abort;
        int   nreq;
        ill = both || (sz == 2'd3) || (sz == 2'd1 && addr[0])
              || (sz == 2'd2 && addr[1:0] != 2'b00);
        begin_cycle();
        mem_read      = rd | both;
        mem_write     = ~rd | both;
        ALU_out       = addr;
        mem_size      = sz;
        load_unsigned = uns;
        Data_out      = wd;
        bus_ack       = 1'($urandom_range(0, 1));
        bus_rdata     = $urandom;
        exp_req       = 1'b0;
        if (ill) begin
            exp_stall = 1'b0;
            err_next  = 1'b1;
            return;
        end
        exp_stall = 1'b1;
        exp_we    = ~rd;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = 4'(((1 << size_bytes(sz)) - 1) << addr[1:0]);
        exp_wd    = store_model(wd, sz);
        nreq      = dly + 1;
        abort     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (dly >= TB_TIMEOUT) begin
            nreq  = TB_TIMEOUT;
            abort = 1'b1;
        end
`endif
        for (int i = 1; i <= nreq; i++) begin
            begin_cycle();
            bus_ack   = (i == dly + 1);
            bus_rdata = (i == dly + 1) ? rdat : $urandom;
            exp_stall = 1'b1;
            exp_req   = 1'b1;
            if (i == rst_at) begin
                checking = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
                chk("rst_Data_in", Data_in, 32'd0);
                chk("rst_stall", {31'b0, stall}, 32'd0);
                chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
                mem_read  = 1'b0;
                mem_write = 1'b0;
                bus_ack   = 1'b0;
                return;
            end
        end
        if (abort) err_next = 1'b1;
        begin_cycle();
        if (!abort && rd) exp_din = load_model(rdat, addr[1:0], sz, uns);
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        exp_din   = '0;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_err   = 1'b0;
        err_next  = 1'b0;
        checking  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd;

        rst = 1'b0;
        ALU_out = '0; Data_out = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'b10; load_unsigned = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        #3;
        chk("reset_Data_in", Data_in, 32'd0);
        chk("reset_bus_req", {31'b0, bus_req}, 32'd0);
        chk("reset_bus_we", {31'b0, bus_we}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_be", {28'b0, bus_be}, 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_mem_err", {31'b0, mem_err}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        idle();

        // Word load, minimum latency.
        s0 = stall_total;
        access(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1'b0, 0);
        #1;
        chk("lit_word_data", Data_in, 32'hDEADBEEF);
        chk("lit_word_be", {28'b0, last_be}, 32'h0000000F);
        chk("lit_word_stall_cycles", 32'(stall_total - s0), 32'd2);

        // Byte loads, signed then unsigned.
        access(1'b1, 32'h13, 2'b00, 1'b0, 32'h0, 32'h80FF0000, 1, 1'b0, 0);
        #1;
        chk("lit_byte_signed", Data_in, 32'hFFFFFF80);
        chk("lit_byte_be", {28'b0, last_be}, 32'h00000008);
        access(1'b1, 32'h13, 2'b00, 1'b1, 32'h0, 32'h80FF0000, 0, 1'b0, 0);
        #1;
        chk("lit_byte_unsigned", Data_in, 32'h00000080);

        // Half store.
        access(1'b0, 32'h22, 2'b01, 1'b0, 32'h1234ABCD, 32'h0, 2, 1'b0, 0);
        #1;
        chk("lit_half_we", {31'b0, last_we}, 32'd1);
        chk("lit_half_be", {28'b0, last_be}, 32'h0000000C);
        chk("lit_half_wdata", last_wd, 32'hABCDABCD);
        chk("lit_half_data_in", Data_in, 32'h00000080);

        // Misaligned word and illegal size.
        idle();
        access(1'b1, 32'h06, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0, 0);
        #1;
        chk("lit_misalign_stall", {31'b0, stall}, 32'd0);
        idle();
        #1;
        chk("lit_misalign_err", {31'b0, mem_err}, 32'd1);
        chk("lit_misalign_req", {31'b0, bus_req}, 32'd0);
        idle();
        #1;
        chk("lit_err_one_cycle", {31'b0, mem_err}, 32'd0);
        access(1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 0, 1'b0, 0);
        idle();
        #1;
        chk("lit_illegal_size_err", {31'b0, mem_err}, 32'd1);
        idle();

        // Delayed ack (or watchdog abort).
        s0 = stall_total;
        access(1'b1, 32'h40, 2'b10, 1'b0, 32'h0, 32'h11223344, 4, 1'b0, 0);
        #1;
`ifdef MEM_TIMEOUT_EN
        chk("lit_timeout_stall_cycles", 32'(stall_total - s0), 32'd5);
        chk("lit_timeout_data_in", Data_in, 32'h00000080);
`else
        chk("lit_delay_stall_cycles", 32'(stall_total - s0), 32'd6);
        chk("lit_delay_data_in", Data_in, 32'h11223344);
`endif
        idle();

        // Reset during REQ, then a normal access.
        access(1'b1, 32'h80, 2'b10, 1'b0, 32'h0, 32'h55667788, 5, 1'b0, 2);
        repeat (2) @(posedge clk);
        release_reset();
        access(1'b1, 32'h84, 2'b10, 1'b0, 32'h0, 32'hCAFE0001, 0, 1'b0, 0);
        #1;
        chk("lit_post_reset_load", Data_in, 32'hCAFE0001);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0] = 1'b0;
            end
            rd = 1'($urandom_range(0, 1));
            access(rd, a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, 6), ($urandom_range(0, 19) == 0), 0);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
